// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv32 core front end.
// Holds the branch_sel encodings produced by the branch control unit, the
// PC sequencer state enumeration and the default reset/trap vectors.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // branch_sel encodings from the branch control unit
    localparam logic [1:0] BSEL_SEQ = 2'b00;
    localparam logic [1:0] BSEL_BR  = 2'b01;
    localparam logic [1:0] BSEL_RSV = 2'b10;
    localparam logic [1:0] BSEL_JMP = 2'b11;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

endpackage : riscv_pkg

// File: rtl/pc_target_mux.sv
// Combinational next-PC target selection.
// Ports:
//   pc_i, imm_i, jump_target_i  : candidate sources for the next PC
//   branch_sel_i                : redirect decision from the branch CU
//   pending_valid_i/target_i    : redirect buffered while fetch was held
//   target_sel_o                : selected next PC
//   misaligned_o                : selected target is not word aligned
module pc_target_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic [1:0]      branch_sel_i,
    input  logic            pending_valid_i,
    input  logic [XLEN-1:0] pending_target_i,
    output logic [XLEN-1:0] target_sel_o,
    output logic            misaligned_o
);

    // Priority select: a buffered redirect always beats the live decision;
    // the reserved encoding falls through to sequential fetch.
    always_comb begin
        target_sel_o = pc_i + XLEN'(32'd4);
        if (pending_valid_i) begin
            target_sel_o = pending_target_i;
        end else begin
            case (branch_sel_i)
                BSEL_BR:  target_sel_o = pc_i + imm_i;
                BSEL_JMP: target_sel_o = {jump_target_i[XLEN-1:1], 1'b0};
                BSEL_SEQ: target_sel_o = pc_i + XLEN'(32'd4);
                BSEL_RSV: target_sel_o = pc_i + XLEN'(32'd4);
                default:  target_sel_o = pc_i + XLEN'(32'd4);
            endcase
        end
    end

    // pc stays word aligned, so pc+4 can never trip this check
    assign misaligned_o = (target_sel_o[1:0] != 2'b00);

endmodule : pc_target_mux

// File: rtl/pc_next_unit.sv
// Program-counter sequencer for the riscv32 single-cycle core.
// Owns the PC register, the instruction fetch request, a one-entry redirect
// buffer used while fetch is held, and misaligned-target trapping.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   branch_sel, imm,
//   jump_target         : redirect decision and targets from branch CU / ALU
//   stall, imem_ready   : fetch hold conditions (only looked at in RUN)
//   pc, pc_plus4        : current PC (registered) and pc+4
//   imem_req            : fetch request for the address on pc
//   misalign_exc        : one-cycle pulse while vectoring to the trap handler
//   exc_pc, exc_tval    : faulting PC and offending target of the last trap
module pc_next_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      branch_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_pc,
    output logic [XLEN-1:0] exc_tval
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pending_valid_q, pending_valid_d;
    logic [XLEN-1:0] pending_target_q, pending_target_d;
    logic [XLEN-1:0] exc_pc_q, exc_pc_d;
    logic [XLEN-1:0] exc_tval_q, exc_tval_d;
    logic            imem_req_q, imem_req_d;
    logic            misalign_exc_q, misalign_exc_d;

    logic [XLEN-1:0] target_sel_s;
    logic            misaligned_s;
    logic            adv_s;

    pc_target_mux #(
        .XLEN (XLEN)
    ) u_target_mux (
        .pc_i             (pc_q),
        .imm_i            (imm),
        .jump_target_i    (jump_target),
        .branch_sel_i     (branch_sel),
        .pending_valid_i  (pending_valid_q),
        .pending_target_i (pending_target_q),
        .target_sel_o     (target_sel_s),
        .misaligned_o     (misaligned_s)
    );

    assign adv_s = (state_q == ST_RUN) && imem_ready && !stall;

    // Next-state logic for the FSM, PC, redirect buffer and exception record
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        exc_pc_d         = exc_pc_q;
        exc_tval_d       = exc_tval_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (adv_s) begin
                    pending_valid_d = 1'b0;
                    if (misaligned_s) begin
                        pc_d       = TRAP_VECTOR;
                        exc_pc_d   = pc_q;
                        exc_tval_d = target_sel_s;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d = target_sel_s;
                    end
                end else if ((branch_sel != BSEL_SEQ) && !pending_valid_q) begin
                    // first redirect seen while held is kept; later ones are dropped
                    pending_valid_d  = 1'b1;
                    pending_target_d = target_sel_s;
                end else begin
                    pending_valid_d = pending_valid_q;
                end
            end
            ST_TRAP: state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        // status outputs are registered from the state being entered
        imem_req_d     = (state_d == ST_RUN);
        misalign_exc_d = (state_d == ST_TRAP);
    end

    // Sequential state with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_VECTOR;
            pending_valid_q  <= 1'b0;
            pending_target_q <= '0;
            exc_pc_q         <= '0;
            exc_tval_q       <= '0;
            imem_req_q       <= 1'b0;
            misalign_exc_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
            exc_pc_q         <= exc_pc_d;
            exc_tval_q       <= exc_tval_d;
            imem_req_q       <= imem_req_d;
            misalign_exc_q   <= misalign_exc_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(32'd4);
    assign imem_req     = imem_req_q;
    assign misalign_exc = misalign_exc_q;
    assign exc_pc       = exc_pc_q;
    assign exc_tval     = exc_tval_q;

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  branch_sel;
    logic [31:0] imm;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        misalign_exc;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_booting;
    bit          m_trapping;
    bit          m_has_pend;
    logic [31:0] m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_tval;

    pc_next_unit dut (
        .clk          (clk),
        .rst          (rst),
        .branch_sel   (branch_sel),
        .imm          (imm),
        .jump_target  (jump_target),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_req     (imem_req),
        .misalign_exc (misalign_exc),
        .exc_pc       (exc_pc),
        .exc_tval     (exc_tval)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: what the sequencer should do at the coming edge.
    task automatic model_edge();
        logic [31:0] dest;
        if (rst) begin
            m_pc = 32'h0; m_booting = 1; m_trapping = 0; m_has_pend = 0;
            m_epc = 32'h0; m_tval = 32'h0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_trapping) begin
            m_trapping = 0;
        end else begin
            if (m_has_pend)                dest = m_pend;
            else if (branch_sel == 2'b01)  dest = m_pc + imm;
            else if (branch_sel == 2'b11)  dest = jump_target & 32'hFFFF_FFFE;
            else                           dest = m_pc + 32'd4;
            if (imem_ready && !stall) begin
                m_has_pend = 0;
                if (dest % 4 != 0) begin
                    m_epc = m_pc; m_tval = dest; m_pc = 32'h100; m_trapping = 1;
                end else begin
                    m_pc = dest;
                end
            end else if (branch_sel != 2'b00 && !m_has_pend) begin
                m_has_pend = 1; m_pend = dest;
            end
        end
    endtask

    task automatic step(input bit r, input logic [1:0] bs, input logic [31:0] im,
                        input logic [31:0] jt, input bit st, input bit rdy);
        rst = r; branch_sel = bs; imm = im; jump_target = jt; stall = st; imem_ready = rdy;
        model_edge();
        @(posedge clk);
        #1;
        check_val("pc", pc, m_pc);
        check_val("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_val("imem_req", {31'd0, imem_req}, {31'd0, !m_booting && !m_trapping});
        check_val("misalign_exc", {31'd0, misalign_exc}, {31'd0, m_trapping});
        check_val("exc_pc", exc_pc, m_epc);
        check_val("exc_tval", exc_tval, m_tval);
    endtask

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_jt;
        m_booting = 1; m_trapping = 0; m_has_pend = 0; m_pend = 32'h0;
        m_pc = 32'h0; m_epc = 32'h0; m_tval = 32'h0;
        rst = 1'b1; branch_sel = 2'b00; imm = 32'h0; jump_target = 32'h0;
        stall = 1'b0; imem_ready = 1'b0;
        #2;

        // reset and boot
        step(1, 2'b00, 0, 0, 0, 1);
        check_val("reset_pc", pc, 32'h0);
        check_val("reset_req", {31'd0, imem_req}, 32'd0);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("boot_pc_hold", pc, 32'h0);
        step(0, 2'b00, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("seq_pc_c", pc, 32'hC);

        // branch and jump
        step(0, 2'b11, 0, 32'h10, 0, 1);
        step(0, 2'b01, 32'h20, 0, 0, 1);
        check_val("branch_0x30", pc, 32'h30);
        step(0, 2'b11, 0, 32'h45, 0, 1);
        check_val("jump_0x44", pc, 32'h44);
        step(0, 2'b10, 32'h80, 32'h80, 0, 1);
        check_val("reserved_seq", pc, 32'h48);

        // stall buffering, later redirect ignored
        step(0, 2'b11, 0, 32'h8, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 2'b01, 32'h40, 0, 0, 0);
        check_val("stall_hold", pc, 32'h8);
        step(0, 2'b11, 0, 32'h200, 1, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("pending_redirect", pc, 32'h48);

        // misaligned branch
        step(0, 2'b11, 0, 32'h20, 0, 1);
        step(0, 2'b01, 32'h6, 0, 0, 1);
        check_val("trap_pc", pc, 32'h100);
        check_val("trap_pulse", {31'd0, misalign_exc}, 32'd1);
        check_val("trap_req", {31'd0, imem_req}, 32'd0);
        check_val("trap_epc", exc_pc, 32'h20);
        check_val("trap_tval", exc_tval, 32'h26);
        step(0, 2'b11, 0, 32'h300, 0, 1);
        check_val("trap_pulse_end", {31'd0, misalign_exc}, 32'd0);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("after_trap", pc, 32'h104);

        // wrap
        step(0, 2'b11, 0, 32'hFFFF_FFFC, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("wrap", pc, 32'h0);

        // reset during a buffered redirect
        step(0, 2'b11, 0, 32'h40, 0, 1);
        step(0, 2'b01, 32'h80, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        check_val("no_redirect_after_rst", pc, 32'h4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_imm = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0FFE)
                                                : ($urandom & 32'hFFFF_FFFC);
            r_jt  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)), r_imm, r_jt,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_next_unit
